fpu_cvt: RTL and testbench

FPU_CVT -- requirements
Module: fpu_cvt

---
 rtl/fpu_cvt.sv | 205 ++++++++++++++++++++
 tb/tb_fpu_cvt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt.sv
// Converts between 32-bit integers and binary32 (FCVT.S.W/S.WU/W.S/WU.S) with a
// shifter that moves at most SHIFT_STEP bits per cycle. Define FPU_CVT_FFLAGS_EN to compute fflags.
// Latency max(1, ceil(shift/SHIFT_STEP)) NORM cycles + ROUND + DONE; start is ignored unless IDLE.
module fpu_cvt #(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [2:0]  flt_rm,
    output logic [31:0] fpu_res,
    output logic        fpu_busy,
    output logic        fpu_done,
    output logic [4:0]  fflags
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic        sign_q, sign_d, spc_q, spc_d, grd_q, grd_d, stk_q, stk_d;
    logic [31:0] val_q, val_d, res_q, res_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic        busy_q, busy_d, done_q, done_d;

    function automatic logic [5:0] lzc(input logic [31:0] v);
        logic [5:0] r;
        r = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = 6'(31 - i);
        return r;
    endfunction

    // rm codes 101-111 fall into the RNE default
    function automatic logic rnd_up(input logic [2:0] rm, input logic s, input logic lsb,
                                    input logic g, input logic st);
        case (rm)
            3'b001:  return 1'b0;
            3'b010:  return s & (g | st);
            3'b011:  return ~s & (g | st);
            3'b100:  return g;
            default: return g & (st | lsb);
        endcase
    endfunction

    logic [7:0]  in_exp;
    logic [5:0]  w_cnt, lz, nl, nr;
    logic        in_nan, w_ovf;
    logic [31:0] val_l, w_mag;
    logic [32:0] sh_r, sh_mask;
    logic        s_up, w_up;
    logic [30:0] s_sum;

    assign in_exp = opa[30:23];
    assign in_nan = (in_exp == 8'hFF) && (opa[22:0] != 23'd0);
    assign w_cnt  = 6'(8'd158 - in_exp);
    // exp 158 fits WU.S; for W.S only exactly -2^31 survives
    assign w_ovf  = (in_exp == 8'd158) ? (!op[0] && !(opa[31] && opa[22:0] == 23'd0))
                                       : (in_exp > 8'd158);

    assign lz      = lzc(val_q);
    assign nl      = (lz < STEP) ? lz : STEP;
    assign val_l   = val_q << nl;
    assign nr      = (cnt_q < STEP) ? cnt_q : STEP;
    assign sh_mask = (33'd1 << nr) - 33'd1;
    assign sh_r    = {val_q, grd_q} >> nr;

    // Exponent/mantissa add lets a mantissa carry ripple into the exponent
    assign s_up  = rnd_up(rm_q, sign_q, val_q[8], val_q[7], |val_q[6:0]);
    assign s_sum = {exp_q, val_q[30:8]} + {30'd0, s_up};
    assign w_up  = rnd_up(rm_q, sign_q, val_q[0], grd_q, stk_q);
    assign w_mag = val_q + {31'd0, w_up};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rm_d    = rm_q;
        sign_d  = sign_q;
        spc_d   = spc_q;
        grd_d   = grd_q;
        stk_d   = stk_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = NORM;
                op_d    = op;
                rm_d    = flt_rm;
                sign_d  = opa[31];
                spc_d   = 1'b0;
                grd_d   = 1'b0;
                stk_d   = 1'b0;
                cnt_d   = 6'd0;
                exp_d   = 8'd158;
                val_d   = opa;
                if (!op[1]) begin
                    if (op[0])       sign_d = 1'b0;
                    else if (opa[31]) val_d = -opa;
                    spc_d = (opa == 32'd0);
                end else if (w_ovf) begin
                    spc_d = 1'b1;
                    if (op[0]) val_d = (opa[31] && !in_nan) ? 32'h0000_0000 : 32'hFFFF_FFFF;
                    else       val_d = (opa[31] && !in_nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else if (in_exp < 8'd126) begin
                    val_d = 32'd0;
                    stk_d = |opa[30:0];
                end else begin
                    val_d = {1'b1, opa[22:0], 8'd0};
                    cnt_d = w_cnt;
                end
            end
            NORM: begin
                if (spc_q) begin
                    state_d = ROUND;
                end else if (!op_q[1]) begin
                    val_d = val_l;
                    exp_d = exp_q - {2'b00, nl};
                    if (val_l[31]) state_d = ROUND;
                end else begin
                    {val_d, grd_d} = sh_r;
                    stk_d = stk_q | (|({val_q, grd_q} & sh_mask));
                    cnt_d = cnt_q - nr;
                    if (cnt_q == nr) state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
                if (spc_q)         res_d = val_q;
                else if (!op_q[1]) res_d = {sign_q, s_sum};
                else if (!op_q[0]) res_d = sign_q ? -w_mag : w_mag;
                else               res_d = sign_q ? 32'd0 : w_mag;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == NORM) || (state_d == ROUND);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            rm_q    <= 3'd0;
            sign_q  <= 1'b0;
            spc_q   <= 1'b0;
            grd_q   <= 1'b0;
            stk_q   <= 1'b0;
            val_q   <= 32'd0;
            cnt_q   <= 6'd0;
            exp_q   <= 8'd0;
            res_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            sign_q  <= sign_d;
            spc_q   <= spc_d;
            grd_q   <= grd_d;
            stk_q   <= stk_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fpu_res  = res_q;
    assign fpu_busy = busy_q;
    assign fpu_done = done_q;

`ifdef FPU_CVT_FFLAGS_EN
    logic [4:0] flags_q, flags_d;
    logic       nv, nx;

    // Saturated float->int results are always invalid; integer zero is not
    always_comb begin
        nv = 1'b0;
        nx = 1'b0;
        if (spc_q)                                        nv = op_q[1];
        else if (!op_q[1])                                nx = val_q[7] | (|val_q[6:0]);
        else if (op_q[0] && sign_q && w_mag != 32'd0)     nv = 1'b1;
        else                                              nx = grd_q | stk_q;
        flags_d = (state_q == ROUND) ? {nv, 3'b000, nx} : flags_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= 5'd0;
        else      flags_q <= flags_d;
    end

    assign fflags = flags_q;
`else
    assign fflags = 5'd0;
`endif
endmodule

// File: tb/tb_fpu_cvt.sv
// Directed and randomized bench for fpu_cvt against an arithmetic reference model.
module tb_fpu_cvt;
    localparam int STEP = 8;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [2:0]  flt_rm;
    logic [31:0] fpu_res;
    logic        fpu_busy, fpu_done;
    logic [4:0]  fflags;

    int checks = 0;
    int errors = 0;

    fpu_cvt #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .flt_rm(flt_rm),
        .fpu_res(fpu_res), .fpu_busy(fpu_busy), .fpu_done(fpu_done), .fflags(fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_rnd(input logic [2:0] rm, input bit s, input bit inx,
                                 input bit above, input bit tie, input bit odd);
        case (rm)
            3'd1:    return 1'b0;
            3'd2:    return s & inx;
            3'd3:    return !s & inx;
            3'd4:    return above | tie;
            default: return above | (tie & odd);
        endcase
    endfunction

    function automatic void m_i2f(input logic [31:0] a, input bit unsgn, input logic [2:0] rm,
                                  output logic [31:0] r, output logic [4:0] f);
        longint unsigned mag, dv, q, rem, half;
        bit s, inx;
        int k;
        s = !unsgn && a[31];
        mag = s ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
        r = 32'd0;
        f = 5'd0;
        if (mag == 0) return;
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k <= 23) begin
            q = mag << (23 - k); rem = 0; half = 1;
        end else begin
            dv = 64'd1 << (k - 23); q = mag / dv; rem = mag % dv; half = dv / 2;
        end
        inx = (rem != 0);
        q = q + 64'(m_rnd(rm, s, inx, rem > half, rem == half, q[0]));
        if (q == (64'd1 << 24)) begin q = q >> 1; k++; end
        r = {s, 8'(k + 127), q[22:0]};
        f = {4'b0000, inx};
    endfunction

    function automatic void m_f2i(input logic [31:0] a, input bit unsgn, input logic [2:0] rm,
                                  output logic [31:0] r, output logic [4:0] f);
        longint unsigned m, ip, rem, half;
        bit s, nan, big, inx, above, tie;
        int e, sh;
        s = a[31];
        e = int'(a[30:23]);
        m = (e == 0) ? {41'd0, a[22:0]} : {40'd0, 1'b1, a[22:0]};
        nan = (e == 255) && (a[22:0] != 0);
        big = 0; ip = 0; inx = 0; above = 0; tie = 0;
        if (e >= 190) big = 1;
        else if (e >= 150) ip = m << (e - 150);
        else begin
            sh = 150 - e;
            if (sh >= 25) inx = (m != 0);
            else begin
                ip = m >> sh; rem = m & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
                inx = (rem != 0); above = (rem > half); tie = (rem == half);
            end
        end
        ip = ip + 64'(m_rnd(rm, s, inx, above, tie, ip[0]));
        f = {4'b0000, inx};
        if (nan) begin
            r = unsgn ? 32'hFFFFFFFF : 32'h7FFFFFFF; f = 5'b10000;
        end else if (unsgn) begin
            if (s && (big || ip != 0))          begin r = 32'd0; f = 5'b10000; end
            else if (s)                          r = 32'd0;
            else if (big || ip > 64'hFFFFFFFF)   begin r = 32'hFFFFFFFF; f = 5'b10000; end
            else                                 r = ip[31:0];
        end else begin
            if (s && (big || ip > 64'h80000000)) begin r = 32'h80000000; f = 5'b10000; end
            else if (s)                          r = -ip[31:0];
            else if (big || ip > 64'h7FFFFFFF)   begin r = 32'h7FFFFFFF; f = 5'b10000; end
            else                                 r = ip[31:0];
        end
    endfunction

    // NORM cycles: one per SHIFT_STEP bits of shift, at least one, one for specials
    function automatic int m_norm(input logic [1:0] o, input logic [31:0] a);
        longint unsigned mag;
        int sh, e;
        sh = 0;
        if (!o[1]) begin
            mag = (!o[0] && a[31]) ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
            if (mag == 0) return 1;
            while (((mag << sh) & 64'h80000000) == 0) sh++;
        end else begin
            e = int'(a[30:23]);
            if (e < 126 || e >= 158) return 1;
            sh = 158 - e;
        end
        return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    endfunction

    task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [2:0] rm, input bit has_exp, input logic [31:0] exp_res,
                             input bit nowait, input bit spam, output int busy_n);
        logic [31:0] mr, r;
        logic [4:0]  mf, ef, f;
        int lat, want_lat;
        if (o[1]) m_f2i(a, o[0], rm, mr, mf);
        else      m_i2f(a, o[0], rm, mr, mf);
`ifdef FPU_CVT_FFLAGS_EN
        ef = mf;
`else
        ef = 5'd0;
`endif
        if (has_exp) mr = exp_res;
        want_lat = m_norm(o, a) + 2;
        if (!nowait) @(negedge clk);
        start = 1'b1; op = o; opa = a; flt_rm = rm;
        @(posedge clk);
        #1;
        start = spam; op = ~o; opa = ~a; flt_rm = ~rm;
        lat = -1;
        busy_n = 0;
        for (int i = 1; i <= 100 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (fpu_busy) busy_n++;
            if (fpu_done) lat = i;
        end
        r = fpu_res;
        f = fflags;
        start = 1'b0;
        checks++;
        assert (lat === want_lat) else begin
            errors++;
            $error("FAIL %s latency got %0d want %0d", tag, lat, want_lat);
        end
        checks++;
        assert (r === mr) else begin
            errors++;
            $error("FAIL %s res got %h want %h", tag, r, mr);
        end
        checks++;
        assert (f === ef) else begin
            errors++;
            $error("FAIL %s fflags got %b want %b", tag, f, ef);
        end
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [2:0]  rm;
        int bn, seen;

        rst = 1'b0; start = 1'b0; op = 2'd0; opa = 32'd0; flt_rm = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        assert ({fpu_res, fpu_busy, fpu_done, fflags} === 39'd0) else begin
            errors++;
            $error("FAIL reset_state got %h want 0", {fpu_res, fpu_busy, fpu_done, fflags});
        end
        rst = 1'b1;

        run_check("sw_one", 2'b00, 32'h00000001, 3'd0, 1, 32'h3F800000, 0, 0, bn);
        checks++;
        assert (bn === 5) else begin
            errors++;
            $error("FAIL sw_one_busy got %0d want 5", bn);
        end
        run_check("sw_tie_rne", 2'b00, 32'h01000001, 3'd0, 1, 32'h4B800000, 0, 0, bn);
        run_check("sw_tie_rup", 2'b00, 32'h01000001, 3'd3, 1, 32'h4B800001, 0, 0, bn);
        run_check("ws_m2p5_rne", 2'b10, 32'hC0200000, 3'd0, 1, 32'hFFFFFFFE, 0, 0, bn);
        run_check("ws_m2p5_rmm", 2'b10, 32'hC0200000, 3'd4, 1, 32'hFFFFFFFD, 0, 0, bn);
        run_check("ws_m2p5_rdn", 2'b10, 32'hC0200000, 3'd2, 1, 32'hFFFFFFFD, 0, 0, bn);
        run_check("ws_ovf", 2'b10, 32'h4F000000, 3'd0, 1, 32'h7FFFFFFF, 0, 0, bn);
        run_check("wus_neg1", 2'b11, 32'hBF800000, 3'd0, 1, 32'h00000000, 0, 0, bn);
        run_check("sw_min", 2'b00, 32'h80000000, 3'd0, 1, 32'hCF000000, 0, 0, bn);
        run_check("swu_max_rtz", 2'b01, 32'hFFFFFFFF, 3'd1, 1, 32'h4F7FFFFF, 0, 0, bn);
        run_check("swu_max_rne", 2'b01, 32'hFFFFFFFF, 3'd0, 1, 32'h4F800000, 0, 0, bn);
        run_check("ws_min_exact", 2'b10, 32'hCF000000, 3'd0, 1, 32'h80000000, 0, 0, bn);
        run_check("ws_nan", 2'b10, 32'hFFC00000, 3'd0, 1, 32'h7FFFFFFF, 0, 0, bn);
        run_check("wus_neg_small", 2'b11, 32'hBE99999A, 3'd0, 1, 32'h00000000, 0, 0, bn);
        run_check("ws_negzero", 2'b10, 32'h80000000, 3'd0, 1, 32'h00000000, 0, 0, bn);
        run_check("sw_zero", 2'b00, 32'h00000000, 3'd3, 1, 32'h00000000, 0, 0, bn);
        run_check("ws_tiny_rup", 2'b10, 32'h00000001, 3'd3, 1, 32'h00000001, 0, 0, bn);
        run_check("busy_start_ignored", 2'b00, 32'h00000001, 3'd0, 1, 32'h3F800000, 0, 1, bn);

        // Abort a long conversion mid-NORM; fpu_res holds a nonzero value beforehand
        @(negedge clk);
        start = 1'b1; op = 2'b00; opa = 32'h00000001; flt_rm = 3'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        assert ({fpu_res, fpu_busy, fpu_done, fflags} === 39'd0) else begin
            errors++;
            $error("FAIL abort_outputs got %h want 0", {fpu_res, fpu_busy, fpu_done, fflags});
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (fpu_done || fpu_busy) seen++;
        end
        checks++;
        assert (seen === 0) else begin
            errors++;
            $error("FAIL abort_no_done got %0d want 0", seen);
        end
        rst = 1'b1;
        run_check("start_after_rst", 2'b00, 32'h00000001, 3'd0, 1, 32'h3F800000, 1, 0, bn);

        for (int n = 0; n < 80; n++) begin
            o  = 2'($urandom_range(0, 3));
            rm = 3'($urandom_range(0, 7));
            if (!o[1]) begin
                a = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) a = -a;
            end else begin
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 162)),
                     23'($urandom) & (($urandom_range(0, 1) == 1) ? 23'h7FFFFF : 23'h7E0000)};
            end
            if ($urandom_range(0, 9) == 0) a = $urandom;
            run_check($sformatf("rnd%0d", n), o, a, rm, 0, 32'd0, 0, 0, bn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
